// File: rtl/imem_pkg.sv
// Shared types for the instruction-memory arbiter: owner states and the
// per-port registered response.
package imem_pkg;

  localparam int IMEM_WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_F = 2'd1,
    OWN_D = 2'd2
  } owner_e;

  typedef struct packed {
    logic                   rvalid;
    logic [IMEM_WORD_W-1:0] rdata;
    logic                   rerr;
  } imem_rsp_t;

endpackage

// File: rtl/imem_arbiter_if.sv
// Bus bundle between the fetch/debug requesters, the arbiter and the
// instruction memory read port.
interface imem_arbiter_if
  import imem_pkg::*;
#(
  parameter int ADDR_W = 32
) ();

  logic                   f_req;
  logic [ADDR_W-1:0]      f_addr;
  logic                   f_gnt;
  logic                   f_rvalid;
  logic [IMEM_WORD_W-1:0] f_rdata;
  logic                   f_rerr;

  logic                   d_req;
  logic [ADDR_W-1:0]      d_addr;
  logic                   d_lock;
  logic                   d_gnt;
  logic                   d_rvalid;
  logic [IMEM_WORD_W-1:0] d_rdata;
  logic                   d_rerr;

  logic [ADDR_W-1:0]      mem_addr;
  logic [IMEM_WORD_W-1:0] mem_rd;

  // Arbiter side.
  modport slave (
    input  f_req, f_addr, d_req, d_addr, d_lock, mem_rd,
    output f_gnt, f_rvalid, f_rdata, f_rerr,
    output d_gnt, d_rvalid, d_rdata, d_rerr, mem_addr
  );

  // Requester/memory side.
  modport master (
    output f_req, f_addr, d_req, d_addr, d_lock, mem_rd,
    input  f_gnt, f_rvalid, f_rdata, f_rerr,
    input  d_gnt, d_rvalid, d_rdata, d_rerr, mem_addr
  );

endinterface

// File: rtl/imem_rsp_reg.sv
// Per-port response register: one-cycle valid pulse per accepted request,
// data and range error captured on that transfer and held otherwise.
module imem_rsp_reg
  import imem_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fire,
  input  logic                   err_in,
  input  logic [IMEM_WORD_W-1:0] data_in,
  output imem_rsp_t              rsp
);

  imem_rsp_t rsp_q, rsp_d;

  // NOTE: rsp_d starts from rsp_q so every field has a value on every path;
  // a field left unassigned on some branch would infer a latch.
  always_comb begin
    rsp_d        = rsp_q;
    rsp_d.rvalid = fire;
    if (fire) begin
      rsp_d.rdata = data_in;
      rsp_d.rerr  = err_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignment only, so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_q <= '0;
    end else begin
      rsp_q <= rsp_d;
    end
  end

  assign rsp = rsp_q;

endmodule

// File: rtl/imem_arbiter.sv
// Two-port arbiter (fetch, debug) for the single combinational imem read port.
// Define IMEM_ARB_RR_EN for round-robin ties; default is fetch-over-debug.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int CAPACITY = 128,
  parameter int ADDR_W   = 32
) (
  input logic           clk,
  input logic           rst_n,
  imem_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(CAPACITY);

  owner_e            state_q, state_d;
  logic              f_gnt, d_gnt;
  logic              lock_active;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_err;
  imem_rsp_t         f_rsp, d_rsp;

  // While debug owns the port with lock held, fetch is shut out entirely.
  always_comb begin
    lock_active = (state_q == OWN_D) && bus.d_lock;
    f_gnt       = 1'b0;
    d_gnt       = 1'b0;
    if (lock_active) begin
      d_gnt = bus.d_req;
`ifdef IMEM_ARB_RR_EN
    end else if (state_q == OWN_F) begin
      d_gnt = bus.d_req;
      f_gnt = bus.f_req & ~bus.d_req;
`endif
    end else begin
      f_gnt = bus.f_req;
      d_gnt = bus.d_req & ~bus.f_req;
    end
  end

  always_comb begin
    state_d = state_q;
    if (f_gnt) begin
      state_d = OWN_F;
    end else if (d_gnt) begin
      state_d = OWN_D;
    end else if (state_q == OWN_D && !bus.d_lock) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Idle cycles present the fetch address so the memory output is warm.
  always_comb begin
    sel_addr = d_gnt ? bus.d_addr : bus.f_addr;
    sel_err  = |sel_addr[ADDR_W-1:IDX_W];
  end

  assign bus.mem_addr = sel_addr;
  assign bus.f_gnt    = f_gnt;
  assign bus.d_gnt    = d_gnt;

  imem_rsp_reg u_f_rsp (
    .clk     (clk),
    .rst_n   (rst_n),
    .fire    (f_gnt),
    .err_in  (sel_err),
    .data_in (bus.mem_rd),
    .rsp     (f_rsp)
  );

  imem_rsp_reg u_d_rsp (
    .clk     (clk),
    .rst_n   (rst_n),
    .fire    (d_gnt),
    .err_in  (sel_err),
    .data_in (bus.mem_rd),
    .rsp     (d_rsp)
  );

  assign bus.f_rvalid = f_rsp.rvalid;
  assign bus.f_rdata  = f_rsp.rdata;
  assign bus.f_rerr   = f_rsp.rerr;
  assign bus.d_rvalid = d_rsp.rvalid;
  assign bus.d_rdata  = d_rsp.rdata;
  assign bus.d_rerr   = d_rsp.rerr;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed scenarios plus randomized traffic checked
// every cycle against a behavioural owner/response model.
module tb_imem_arbiter;

  localparam int CAPACITY = 128;
  localparam int ADDR_W   = 32;
  localparam int IDX_W    = $clog2(CAPACITY);
`ifdef IMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  imem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  imem_arbiter #(.CAPACITY(CAPACITY), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input int i);
    logic [31:0] v;
    v = i;
    return (32'h9E37_79B9 * (v + 32'd1)) ^ {v[15:0], 16'h5A5A};
  endfunction

  always_comb bus.mem_rd = rom_word(int'(bus.mem_addr[IDX_W-1:0]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Owner encoding in the model: 0 none, 1 fetch, 2 debug.
  int          m_own;
  logic        m_f_rvalid, m_f_rerr, m_d_rvalid, m_d_rerr;
  logic [31:0] m_f_rdata, m_d_rdata;

  function automatic void model_gnt(input int own, input logic fr, input logic dr,
                                    input logic dl, output logic gf, output logic gd);
    gf = 1'b0;
    gd = 1'b0;
    if (own == 2 && dl) gd = dr;
    else if (RR && own == 1 && fr && dr) gd = 1'b1;
    else if (fr) gf = 1'b1;
    else if (dr) gd = 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic gf, gd;
    if (!rst_n) begin
      m_own <= 0;
      m_f_rvalid <= 1'b0; m_f_rdata <= '0; m_f_rerr <= 1'b0;
      m_d_rvalid <= 1'b0; m_d_rdata <= '0; m_d_rerr <= 1'b0;
    end else begin
      model_gnt(m_own, bus.f_req, bus.d_req, bus.d_lock, gf, gd);
      m_f_rvalid <= gf;
      m_d_rvalid <= gd;
      if (gf) begin
        m_f_rdata <= rom_word(int'(bus.f_addr % CAPACITY));
        m_f_rerr  <= (bus.f_addr >= CAPACITY);
      end
      if (gd) begin
        m_d_rdata <= rom_word(int'(bus.d_addr % CAPACITY));
        m_d_rerr  <= (bus.d_addr >= CAPACITY);
      end
      if (gf) m_own <= 1;
      else if (gd) m_own <= 2;
      else if (m_own == 2 && !bus.d_lock) m_own <= 0;
    end
  end

  always @(negedge clk) begin
    logic gf, gd;
    model_gnt(m_own, bus.f_req, bus.d_req, bus.d_lock, gf, gd);
    check("f_gnt", 32'(bus.f_gnt), 32'(gf));
    check("d_gnt", 32'(bus.d_gnt), 32'(gd));
    check("mem_addr", bus.mem_addr, gd ? bus.d_addr : bus.f_addr);
    check("f_rvalid", 32'(bus.f_rvalid), 32'(m_f_rvalid));
    check("f_rdata", bus.f_rdata, m_f_rdata);
    check("f_rerr", 32'(bus.f_rerr), 32'(m_f_rerr));
    check("d_rvalid", 32'(bus.d_rvalid), 32'(m_d_rvalid));
    check("d_rdata", bus.d_rdata, m_d_rdata);
    check("d_rerr", 32'(bus.d_rerr), 32'(m_d_rerr));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] tie_f, tie_d;
    logic       gf_s, gd_s;
    rst_n      = 1'b0;
    bus.f_req  = 1'b0;
    bus.f_addr = '0;
    bus.d_req  = 1'b0;
    bus.d_addr = '0;
    bus.d_lock = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst f_rvalid", 32'(bus.f_rvalid), 32'd0);
    check("rst d_rvalid", 32'(bus.d_rvalid), 32'd0);
    check("rst f_rdata", bus.f_rdata, 32'd0);
    check("rst d_rdata", bus.d_rdata, 32'd0);

    // First fetch after reset.
    tick();
    rst_n = 1'b1;
    bus.f_req = 1'b1; bus.f_addr = 32'd5;
    @(negedge clk);
    check("first f_gnt", 32'(bus.f_gnt), 32'd1);
    tick();
    bus.f_req = 1'b0;
    @(negedge clk);
    check("first f_rvalid", 32'(bus.f_rvalid), 32'd1);
    check("first f_rdata", bus.f_rdata, rom_word(5));

    // One debug read with lock low, then an empty cycle returns to IDLE.
    tick();
    bus.d_req = 1'b1; bus.d_addr = 32'd3;
    tick();
    bus.d_req = 1'b0;
    tick();

    // Simultaneous requests for four cycles.
    tie_f = RR ? 4'b0101 : 4'b1111;
    tie_d = RR ? 4'b1010 : 4'b0000;
    bus.f_req = 1'b1; bus.f_addr = 32'd20;
    bus.d_req = 1'b1; bus.d_addr = 32'd21;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("tie f_gnt", 32'(bus.f_gnt), 32'(tie_f[i]));
      check("tie d_gnt", 32'(bus.d_gnt), 32'(tie_d[i]));
      tick();
    end
    bus.f_req = 1'b0;
    bus.d_req = 1'b1;

    // Locked debug burst shuts out fetch even with d_req low.
    bus.d_addr = 32'd10; bus.d_lock = 1'b1;
    tick();
    bus.d_req = 1'b0;
    bus.f_req = 1'b1; bus.f_addr = 32'd7;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("lock f_gnt", 32'(bus.f_gnt), 32'd0);
      if (i == 0) check("lock d_rdata", bus.d_rdata, rom_word(10));
      tick();
    end
    bus.d_lock = 1'b0;
    @(negedge clk);
    check("unlock f_gnt", 32'(bus.f_gnt), 32'd1);
    tick();
    bus.f_req = 1'b0;

    // Out-of-range debug address wraps and flags an error.
    bus.d_req = 1'b1; bus.d_addr = 32'd130;
    tick();
    bus.d_req = 1'b0;
    @(negedge clk);
    check("oor d_rvalid", 32'(bus.d_rvalid), 32'd1);
    check("oor d_rerr", 32'(bus.d_rerr), 32'd1);
    check("oor d_rdata", bus.d_rdata, rom_word(2));

    // Streaming fetch 0..7 with no bubbles.
    tick();
    bus.f_req = 1'b1; bus.f_addr = 32'd0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i < 7) bus.f_addr = 32'(i + 1);
      else bus.f_req = 1'b0;
      @(negedge clk);
      check("stream f_rvalid", 32'(bus.f_rvalid), 32'd1);
      check("stream f_rdata", bus.f_rdata, rom_word(i));
    end

    // Reset right after a locked debug grant drops the response.
    tick();
    bus.d_req = 1'b1; bus.d_addr = 32'd4; bus.d_lock = 1'b1;
    tick();
    bus.d_req = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst mid d_rvalid", 32'(bus.d_rvalid), 32'd0);
    check("rst mid d_rdata", bus.d_rdata, 32'd0);
    tick();
    rst_n = 1'b1;
    bus.f_req = 1'b1; bus.f_addr = 32'd9;
    @(negedge clk);
    check("post rst f_gnt", 32'(bus.f_gnt), 32'd1);
    tick();
    bus.f_req = 1'b0; bus.d_lock = 1'b0;

    // Randomized traffic; requests are held until granted.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      gf_s = bus.f_gnt;
      gd_s = bus.d_gnt;
      tick();
      rst_n = ($urandom_range(0, 299) != 0);
      if (!(bus.f_req && !gf_s)) bus.f_req = ($urandom_range(0, 3) != 0);
      if (!(bus.d_req && !gd_s)) bus.d_req = ($urandom_range(0, 2) == 0);
      bus.f_addr = 32'($urandom_range(0, 159));
      bus.d_addr = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 159));
      bus.d_lock = ($urandom_range(0, 3) == 0);
    end

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Two-port arbiter in front of the single combinational read port of the instruction memory. Shares it between the core fetch stage and a debug/loader port. Each cycle it grants at most one requester, drives that requester's address to the memory, and registers the returned word. The response appears one cycle later with a per-port valid.

## Interface
- `CAPACITY`, 128, instruction memory depth in 32-bit words; `IDX_W = $clog2(CAPACITY)`.
- `ADDR_W`, 32, requester address width (word index, not byte address).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `f_req`  in  1  fetch request.
- `f_addr`  in  ADDR_W  fetch word index.
- `f_gnt`  out  1  fetch request accepted this cycle.
- `f_rvalid`  out  1  fetch response valid.
- `f_rdata`  out  32  fetch response word.
- `f_rerr`  out  1  fetch response address out of range.
- `d_req`, `d_addr`, `d_gnt`, `d_rvalid`, `d_rdata`, `d_rerr`: same as the fetch signals, for the debug port.
- `d_lock`  in  1  debug holds ownership while high (burst reads).
- `mem_addr`  out  ADDR_W  address to instruction memory.
- `mem_rd`  in  32  combinational read data from memory.

## Operation
- Grant is combinational from `*_req`, the state register, and `d_lock`. A transfer occurs when `req && gnt` is true at a rising edge.
- Owner FSM states:
  - IDLE: reset state, no previous grant.
  - OWN_F: last grant went to fetch.
  - OWN_D: last grant went to debug.
- FSM transitions, on each edge:
  - Granted fetch -> OWN_F.
  - Granted debug -> OWN_D.
  - No grant -> stay in the current state, except OWN_D with `d_lock` low -> IDLE.
- Priority without the macro: fetch over debug.
- Lock: in OWN_D with `d_lock` high, debug is the only eligible requester. `f_gnt` stays 0 even if `d_req` is low. Lock is ignored in IDLE and OWN_F until debug wins a grant once.
- `mem_addr` equals the granted requester's address. With no grant it holds the fetch address (`f_addr`).
- Response:
  - On the edge after a grant, the granted port's `rvalid` goes to 1 for exactly one cycle.
  - `rdata` captures `mem_rd`.
  - `rerr` = (address bits [ADDR_W-1:IDX_W] nonzero). The data word is still returned, from the index wrapped to IDX_W bits.
- Non-granted port: `rvalid` 0. `rdata` and `rerr` hold their last value.
- Back-to-back grants to the same port give one response per cycle with no bubble.

## Timing
- Request-to-response latency is exactly 1 cycle. Sustained throughput is 1 word per cycle, summed over both ports.
- Reset values:
  - State = IDLE.
  - `f_rvalid` = `d_rvalid` = 0.
  - `f_rdata` = `d_rdata` = 0.
  - `f_rerr` = `d_rerr` = 0.
  - `f_gnt` and `d_gnt` follow requests combinationally from IDLE.
- Reset asserted mid-transfer: the pending response is discarded and valids drop immediately (asynchronous). The first grant after deassertion is evaluated from IDLE.
- Requests must be held until granted. Address changes while ungranted are legal; the address sampled is the one present in the grant cycle.
- Both requesters in the same cycle: exactly one grant per the priority rules. Never both grants high.

## Configuration
- `IMEM_ARB_RR_EN` defined: round-robin with no lock active.
  - IDLE or OWN_D -> fetch wins a tie.
  - OWN_F -> debug wins a tie.
- `IMEM_ARB_RR_EN` undefined: fixed priority, fetch over debug.
- Lock behaviour is identical in both builds.

## Structure
- Package `imem_pkg`:
  - `owner_e` enum {IDLE, OWN_F, OWN_D}.
  - `IMEM_WORD_W = 32`.
  - `imem_rsp_t` struct {rvalid, rdata, rerr}.
- One sub-module, `imem_rsp_reg`: the per-port response register (valid pulse, data and err capture), instantiated twice.
- Top level holds the FSM, grant logic, and address mux.

## Test plan
- Reset, no requests -> all valids 0, `rdata` 0, state IDLE. Release reset, `f_req` with `f_addr`=5 -> `f_gnt`=1; next cycle `f_rvalid`=1, `f_rdata`=ROM[5].
- `f_req` and `d_req` together for 4 cycles, fixed build -> `f_gnt` all 4 cycles, `d_gnt` 0. RR build -> grants alternate F,D,F,D.
- Debug reads addr 10, then `d_lock`=1 with `d_req` low for 3 cycles while `f_req`=1 -> `f_gnt`=0 for those 3 cycles. `d_lock`=0 -> `f_gnt`=1 next cycle.
- `d_addr`=130, CAPACITY=128 -> `d_rvalid`=1, `d_rerr`=1, `d_rdata`=ROM[2].
- Fetch streaming addrs 0..7 -> 8 consecutive `f_rvalid` cycles with ROM[0..7] in order, no bubbles.
- Assert `rst_n` low the cycle after a grant -> no `rvalid` pulse observed. State IDLE after release.
